id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH_P, default 32, operand/data width.
REQ-002 SHALL have parameter ADDR_WIDTH_P, default 5, register address width.
REQ-003 SHALL have parameter CNTRL_WIDTH_P, default 3, ALU control width.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 i_valid  in  1  decode stage presents an instruction.
REQ-007 o_ready  out  1  stage can accept; registered output.
REQ-008 i_aluop  in  2  00 add, 01 sub, 10 decode i_funct, 11 illegal.
REQ-009 i_funct  in  6  R-type function field.
REQ-010 i_rs_addr, i_rt_addr, i_dest_addr  in  ADDR_WIDTH_P each  source/destination register numbers.
REQ-011 i_rs_data, i_rt_data, i_imm  in  DATA_WIDTH_P each  register-file reads, sign-extended immediate.
REQ-012 i_alusrc  in  1  1 = operand B from immediate.
REQ-013 i_flush  in  1  discard all held and incoming entries.
REQ-014 i_exm_we, i_exm_addr, i_exm_data  in  1/ADDR/DATA  EX/MEM forwarding source.
REQ-015 i_wb_we, i_wb_addr, i_wb_data  in  1/ADDR/DATA  MEM/WB forwarding source.
REQ-016 o_valid  out  1  head entry valid to execute.
REQ-017 i_ready  in  1  execute stage accepts head entry.
REQ-018 o_control  out  CNTRL_WIDTH_P  ALU control code; o_a, o_b  out  DATA_WIDTH_P  ALU operands.
REQ-019 o_dest_addr  out  ADDR_WIDTH_P; o_illegal  out  1  unsupported opcode/funct flag.

Function
REQ-020 Decode at capture: aluop 00->010, 01->110; aluop 10 with funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
REQ-021 Any other aluop/funct SHALL store control 010 with illegal=1; entry still flows normally.
REQ-022 Storage SHALL be a 2-entry skid buffer, states EMPTY, ONE, FULL; o_ready = 1 in EMPTY/ONE, 0 in FULL, registered.
REQ-023 Accept = i_valid & o_ready; retire = o_valid & i_ready; both in one cycle SHALL keep occupancy and order.
REQ-024 Transitions: EMPTY-accept->ONE; ONE-accept-only->FULL; ONE-retire-only->EMPTY; FULL-retire->ONE; FULL ignores i_valid.
REQ-025 Order SHALL be FIFO; o_valid=1 whenever state is ONE or FULL; head payload stable while o_valid & !i_ready.
REQ-026 i_flush SHALL force EMPTY next cycle, dropping held entries and any same-cycle accept; flush beats accept and retire.
REQ-027 o_a: head rs_addr!=0 & exm_we & exm_addr==rs_addr -> i_exm_data; else rs_addr!=0 & wb_we & wb_addr==rs_addr -> i_wb_data; else stored rs_data.
REQ-028 o_b: stored alusrc=1 -> stored imm; else same forwarding priority on rt_addr/rt_data.
REQ-029 Forwarding SHALL be combinational from head entry and current forward inputs (zero latency); register 0 never forwarded.
REQ-030 Pipeline latency SHALL be 1 cycle: accept at edge N gives o_valid at N+1 when empty.

Reset
REQ-031 reset low SHALL immediately set state EMPTY, o_valid 0, o_ready 0 while asserted.
REQ-032 Outputs o_control, o_a, o_b, o_dest_addr, o_illegal SHALL be 0 during reset and while o_valid=0 (forwarding bypass gated off).
REQ-033 o_ready SHALL rise on the first rising clk edge after reset deasserts; reset mid-transfer SHALL drop all entries.

Configuration
REQ-034 Macro ID_EX_FORWARD_EN defined: forwarding per REQ-027..029.
REQ-035 ID_EX_FORWARD_EN undefined: forwarding ports present but ignored; o_a = stored rs_data, o_b = imm or stored rt_data.

Verification
REQ-036 Accept aluop=10 funct=101010 rs_data=3 rt_data=7, i_ready=1 -> next cycle o_valid=1, o_control=111, o_a=3, o_b=7.
REQ-037 Hold i_ready=0, push 3 entries -> o_ready=0 after 2, third not accepted; release -> entries exit in order A,B, then C accepted.
REQ-038 Head rs_addr=5, exm_we=1 exm_addr=5 exm_data=AA, wb_we=1 wb_addr=5 wb_data=BB -> o_a=AA; exm_we=0 -> o_a=BB; rs_addr=0 -> stored value.
REQ-039 FULL with i_valid=1 and i_flush=1 same cycle -> next cycle o_valid=0, state EMPTY, o_ready=1, no entry emerges.
REQ-040 aluop=10 funct=000000 -> o_illegal=1, o_control=010; assert reset=0 mid-burst -> o_valid=0 immediately, outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/execute pipeline register built as a 2-entry skid buffer.
// The ALU control is decoded when an entry is captured. Operands are muxed
// combinationally from the head entry. Optional operand forwarding from the
// EX/MEM and MEM/WB stages is compiled in when ID_EX_FORWARD_EN is defined.
// Without that macro the forwarding ports exist but have no effect.
//
// state | meaning
// EMPTY | no entries held, o_valid low
// ONE   | head entry only
// FULL  | head and tail held, o_ready low
module id_ex_stage #(
    parameter int DATA_WIDTH_P  = 32,
    parameter int ADDR_WIDTH_P  = 5,
    parameter int CNTRL_WIDTH_P = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [1:0]               i_aluop,
    input  logic [5:0]               i_funct,
    input  logic [ADDR_WIDTH_P-1:0]  i_rs_addr,
    input  logic [ADDR_WIDTH_P-1:0]  i_rt_addr,
    input  logic [ADDR_WIDTH_P-1:0]  i_dest_addr,
    input  logic [DATA_WIDTH_P-1:0]  i_rs_data,
    input  logic [DATA_WIDTH_P-1:0]  i_rt_data,
    input  logic [DATA_WIDTH_P-1:0]  i_imm,
    input  logic                     i_alusrc,
    input  logic                     i_flush,
    input  logic                     i_exm_we,
    input  logic [ADDR_WIDTH_P-1:0]  i_exm_addr,
    input  logic [DATA_WIDTH_P-1:0]  i_exm_data,
    input  logic                     i_wb_we,
    input  logic [ADDR_WIDTH_P-1:0]  i_wb_addr,
    input  logic [DATA_WIDTH_P-1:0]  i_wb_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [CNTRL_WIDTH_P-1:0] o_control,
    output logic [DATA_WIDTH_P-1:0]  o_a,
    output logic [DATA_WIDTH_P-1:0]  o_b,
    output logic [ADDR_WIDTH_P-1:0]  o_dest_addr,
    output logic                     o_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNTRL_WIDTH_P-1:0] control;
        logic                     illegal;
        logic [ADDR_WIDTH_P-1:0]  dest_addr;
        logic [ADDR_WIDTH_P-1:0]  rs_addr;
        logic [ADDR_WIDTH_P-1:0]  rt_addr;
        logic [DATA_WIDTH_P-1:0]  rs_data;
        logic [DATA_WIDTH_P-1:0]  rt_data;
        logic [DATA_WIDTH_P-1:0]  imm;
        logic                     alusrc;
    } entry_t;

    localparam logic [CNTRL_WIDTH_P-1:0] CTRL_ADD = CNTRL_WIDTH_P'(3'b010);
    localparam logic [CNTRL_WIDTH_P-1:0] CTRL_SUB = CNTRL_WIDTH_P'(3'b110);
    localparam logic [CNTRL_WIDTH_P-1:0] CTRL_AND = CNTRL_WIDTH_P'(3'b000);
    localparam logic [CNTRL_WIDTH_P-1:0] CTRL_OR  = CNTRL_WIDTH_P'(3'b001);
    localparam logic [CNTRL_WIDTH_P-1:0] CTRL_SLT = CNTRL_WIDTH_P'(3'b111);

    state_t state_q, state_d;
    logic   ready_q, ready_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry;
    logic   accept;
    logic   retire;
    logic [DATA_WIDTH_P-1:0] a_sel;
    logic [DATA_WIDTH_P-1:0] b_sel;

    assign o_ready = ready_q;
    assign o_valid = (state_q != ST_EMPTY);
    assign accept  = i_valid & ready_q;
    assign retire  = o_valid & i_ready;

    // Decode the incoming instruction into the entry that would be captured;
    // unsupported codes still flow, flagged illegal with an add control.
    always_comb begin
        new_entry           = '0;
        new_entry.dest_addr = i_dest_addr;
        new_entry.rs_addr   = i_rs_addr;
        new_entry.rt_addr   = i_rt_addr;
        new_entry.rs_data   = i_rs_data;
        new_entry.rt_data   = i_rt_data;
        new_entry.imm       = i_imm;
        new_entry.alusrc    = i_alusrc;
        new_entry.control   = CTRL_ADD;
        new_entry.illegal   = 1'b0;
        case (i_aluop)
            2'b00: new_entry.control = CTRL_ADD;
            2'b01: new_entry.control = CTRL_SUB;
            2'b10: begin
                case (i_funct)
                    6'b100000: new_entry.control = CTRL_ADD;
                    6'b100010: new_entry.control = CTRL_SUB;
                    6'b100100: new_entry.control = CTRL_AND;
                    6'b100101: new_entry.control = CTRL_OR;
                    6'b101010: new_entry.control = CTRL_SLT;
                    default:   new_entry.illegal = 1'b1;
                endcase
            end
            default: new_entry.illegal = 1'b1;
        endcase
    end

    // Occupancy FSM and entry movement; flush overrides accept and retire.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        tail_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (retire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (retire) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_FULL);
    end

    // State, ready and payload registers; reset drops every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef ID_EX_FORWARD_EN
    // Zero-latency operand bypass; the nearer EX/MEM result wins, r0 never bypassed.
    always_comb begin
        a_sel = head_q.rs_data;
        if (head_q.rs_addr != '0 && i_exm_we && i_exm_addr == head_q.rs_addr) begin
            a_sel = i_exm_data;
        end else if (head_q.rs_addr != '0 && i_wb_we && i_wb_addr == head_q.rs_addr) begin
            a_sel = i_wb_data;
        end
        b_sel = head_q.rt_data;
        if (head_q.alusrc) begin
            b_sel = head_q.imm;
        end else if (head_q.rt_addr != '0 && i_exm_we && i_exm_addr == head_q.rt_addr) begin
            b_sel = i_exm_data;
        end else if (head_q.rt_addr != '0 && i_wb_we && i_wb_addr == head_q.rt_addr) begin
            b_sel = i_wb_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{i_exm_we, i_exm_addr, i_exm_data, i_wb_we, i_wb_addr,
                          i_wb_data, head_q.rs_addr, head_q.rt_addr};

    // Operands come straight from the stored entry.
    always_comb begin
        a_sel = head_q.rs_data;
        b_sel = head_q.alusrc ? head_q.imm : head_q.rt_data;
    end
`endif

    assign o_control   = o_valid ? head_q.control   : '0;
    assign o_illegal   = o_valid ? head_q.illegal   : 1'b0;
    assign o_dest_addr = o_valid ? head_q.dest_addr : '0;
    assign o_a         = o_valid ? a_sel            : '0;
    assign o_b         = o_valid ? b_sel            : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: queue-based reference model checked every cycle,
// a decode vector table, directed corner sequences and a random phase.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, o_ready, i_alusrc, i_flush, o_valid, i_ready, o_illegal;
    logic [1:0]  i_aluop;
    logic [5:0]  i_funct;
    logic [4:0]  i_rs_addr, i_rt_addr, i_dest_addr, i_exm_addr, i_wb_addr, o_dest_addr;
    logic [31:0] i_rs_data, i_rt_data, i_imm, i_exm_data, i_wb_data, o_a, o_b;
    logic        i_exm_we, i_wb_we;
    logic [2:0]  o_control;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_aluop(i_aluop), .i_funct(i_funct), .i_rs_addr(i_rs_addr),
        .i_rt_addr(i_rt_addr), .i_dest_addr(i_dest_addr), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm(i_imm), .i_alusrc(i_alusrc), .i_flush(i_flush),
        .i_exm_we(i_exm_we), .i_exm_addr(i_exm_addr), .i_exm_data(i_exm_data),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_control(o_control), .o_a(o_a),
        .o_b(o_b), .o_dest_addr(o_dest_addr), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic        ill;
        logic [4:0]  dest, rs, rt;
        logic [31:0] rsd, rtd, imm;
        logic        alusrc;
    } ment_t;

    ment_t mq[$];
    logic  m_ready = 1'b0;

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [2:0] exp_ctrl;
        logic       exp_ill;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 4'b0_010;
        if (op == 2'd1) return 4'b0_110;
        if (op == 2'd2) begin
            if (f == 6'd32) return 4'b0_010;
            if (f == 6'd34) return 4'b0_110;
            if (f == 6'd36) return 4'b0_000;
            if (f == 6'd37) return 4'b0_001;
            if (f == 6'd42) return 4'b0_111;
        end
        return 4'b1_010;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] stored);
        if (FWD_EN && addr != 0 && i_exm_we && i_exm_addr == addr) return i_exm_data;
        if (FWD_EN && addr != 0 && i_wb_we && i_wb_addr == addr) return i_wb_data;
        return stored;
    endfunction

    task automatic check_model(input string tag);
        ment_t h;
        logic [31:0] ea, eb;
        chk({tag, ".ready"}, o_ready, m_ready);
        if (mq.size() == 0) begin
            chk({tag, ".valid"}, o_valid, 0);
            chk({tag, ".ctrl"}, o_control, 0);
            chk({tag, ".ill"}, o_illegal, 0);
            chk({tag, ".dest"}, o_dest_addr, 0);
            chk({tag, ".a"}, o_a, 0);
            chk({tag, ".b"}, o_b, 0);
        end else begin
            h  = mq[0];
            ea = ref_fwd(h.rs, h.rsd);
            eb = h.alusrc ? h.imm : ref_fwd(h.rt, h.rtd);
            chk({tag, ".valid"}, o_valid, 1);
            chk({tag, ".ctrl"}, o_control, h.ctrl);
            chk({tag, ".ill"}, o_illegal, h.ill);
            chk({tag, ".dest"}, o_dest_addr, h.dest);
            chk({tag, ".a"}, o_a, ea);
            chk({tag, ".b"}, o_b, eb);
        end
    endtask

    task automatic model_update();
        ment_t e;
        logic [3:0] d;
        logic acc, ret;
        if (!reset) return;
        acc = i_valid & m_ready;
        ret = (mq.size() > 0) & i_ready;
        if (i_flush) begin
            mq.delete();
        end else begin
            if (ret) void'(mq.pop_front());
            if (acc) begin
                d = ref_decode(i_aluop, i_funct);
                e.ctrl = d[2:0]; e.ill = d[3];
                e.dest = i_dest_addr; e.rs = i_rs_addr; e.rt = i_rt_addr;
                e.rsd = i_rs_data; e.rtd = i_rt_data; e.imm = i_imm; e.alusrc = i_alusrc;
                mq.push_back(e);
            end
        end
        m_ready = (mq.size() < 2);
    endtask

    // Called at a negedge with inputs set; checks, crosses one posedge, returns at negedge.
    task automatic tick(input string tag);
        #1 check_model(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic src, input logic [31:0] imm);
        i_aluop = op; i_funct = f; i_rs_addr = rs; i_rt_addr = rt;
        i_dest_addr = rs ^ rt ^ 5'd9; i_rs_data = rsd; i_rt_data = rtd;
        i_alusrc = src; i_imm = imm;
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        mq.delete();
        m_ready = 1'b0;
        #1;
        chk("rst.valid", o_valid, 0);
        chk("rst.ready", o_ready, 0);
        chk("rst.a", o_a, 0);
        chk("rst.ctrl", o_control, 0);
    endtask

    initial begin
        logic [5:0] legal_f[5];
        legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        vt[0] = '{2'b00, 6'h3f, 3'b010, 1'b0};
        vt[1] = '{2'b01, 6'h00, 3'b110, 1'b0};
        vt[2] = '{2'b10, 6'h20, 3'b010, 1'b0};
        vt[3] = '{2'b10, 6'h22, 3'b110, 1'b0};
        vt[4] = '{2'b10, 6'h24, 3'b000, 1'b0};
        vt[5] = '{2'b10, 6'h25, 3'b001, 1'b0};
        vt[6] = '{2'b10, 6'h2a, 3'b111, 1'b0};
        vt[7] = '{2'b10, 6'h00, 3'b010, 1'b1};
        vt[8] = '{2'b11, 6'h20, 3'b010, 1'b1};

        reset = 1'b0; i_valid = 0; i_ready = 0; i_flush = 0;
        i_exm_we = 0; i_exm_addr = 0; i_exm_data = 0;
        i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
        set_instr(2'b00, 6'h0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        tick("reset0");
        tick("reset1");
        reset = 1'b1;
        tick("rel");
        chk("rel.ready_rises", o_ready, 1);

        // Decode table, streaming with i_ready=1
        i_ready = 1;
        foreach (vt[k]) begin
            i_valid = 1;
            set_instr(vt[k].aluop, vt[k].funct, 5'd1, 5'd2, 32'd100 + k, 32'd200 + k, 1'b0, 32'd0);
            tick("table");
            #1;
            chk("table.ctrl", o_control, vt[k].exp_ctrl);
            chk("table.ill", o_illegal, vt[k].exp_ill);
        end
        i_valid = 0;
        tick("drain");

        // SLT with rs=3, rt=7, one-cycle latency
        i_valid = 1;
        set_instr(2'b10, 6'b101010, 5'd3, 5'd4, 32'd3, 32'd7, 1'b0, 32'd0);
        tick("slt");
        i_valid = 0;
        #1;
        chk("slt.valid", o_valid, 1);
        chk("slt.ctrl", o_control, 3'b111);
        chk("slt.a", o_a, 3);
        chk("slt.b", o_b, 7);
        tick("slt.drain");

        // Backpressure: A, B accepted, C refused until space frees
        i_ready = 0; i_valid = 1;
        set_instr(2'b00, 6'h0, 5'd1, 5'd2, 32'hA, 32'h1, 1'b0, 32'd0); tick("bp.A");
        set_instr(2'b01, 6'h0, 5'd1, 5'd2, 32'hB, 32'h2, 1'b0, 32'd0); tick("bp.B");
        #1 chk("bp.ready_full", o_ready, 0);
        set_instr(2'b00, 6'h0, 5'd1, 5'd2, 32'hC, 32'h3, 1'b1, 32'h33);
        tick("bp.C0"); tick("bp.C1");
        #1 chk("bp.head_A", o_a, 32'hA);
        i_ready = 1;
        tick("bp.retA");
        #1 chk("bp.head_B", o_a, 32'hB);
        tick("bp.retB_accC");
        i_valid = 0;
        #1 chk("bp.head_C", o_a, 32'hC);
        tick("bp.retC");
        #1 chk("bp.empty", o_valid, 0);

        // Forwarding priority on rs
        i_ready = 0; i_valid = 1;
        set_instr(2'b00, 6'h0, 5'd5, 5'd6, 32'h11, 32'h22, 1'b0, 32'd0);
        tick("fw.load");
        i_valid = 0;
        i_exm_we = 1; i_exm_addr = 5; i_exm_data = 32'hAA;
        i_wb_we = 1;  i_wb_addr = 5;  i_wb_data = 32'hBB;
        #1 chk("fw.exm", o_a, FWD_EN ? 32'hAA : 32'h11);
        i_exm_we = 0;
        #1 chk("fw.wb", o_a, FWD_EN ? 32'hBB : 32'h11);
        tick("fw.hold");
        i_ready = 1;
        tick("fw.ret");
        i_valid = 1; i_ready = 0;
        set_instr(2'b00, 6'h0, 5'd0, 5'd0, 32'h44, 32'h55, 1'b0, 32'd0);
        i_exm_we = 1; i_exm_addr = 0; i_wb_addr = 0;
        tick("fw.r0load");
        i_valid = 0;
        #1 chk("fw.r0", o_a, 32'h44);
        i_exm_we = 0; i_wb_we = 0;
        i_ready = 1;
        tick("fw.r0ret");

        // Flush while FULL with a same-cycle offer
        i_ready = 0; i_valid = 1;
        tick("fl.1"); tick("fl.2");
        i_flush = 1;
        tick("fl.flush");
        i_flush = 0; i_valid = 0;
        #1;
        chk("fl.valid", o_valid, 0);
        chk("fl.ready", o_ready, 1);
        i_ready = 1;
        tick("fl.after1"); tick("fl.after2");

        // Reset in the middle of a burst
        i_valid = 1; i_ready = 0;
        set_instr(2'b10, 6'h00, 5'd7, 5'd8, 32'h77, 32'h88, 1'b0, 32'd0);
        tick("rb.1");
        #1 chk("rb.ill", o_illegal, 1);
        tick("rb.2");
        #2;
        assert_reset();
        tick("rb.inrst");
        reset = 1'b1;
        tick("rb.rel");

        // Random phase
        for (int n = 0; n < 400; n++) begin
            i_valid  = ($urandom_range(0, 3) != 0);
            i_ready  = ($urandom_range(0, 2) != 0);
            i_flush  = ($urandom_range(0, 19) == 0);
            i_aluop  = 2'($urandom_range(0, 3));
            i_funct  = ($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
            i_rs_addr = 5'($urandom_range(0, 3));
            i_rt_addr = 5'($urandom_range(0, 3));
            i_dest_addr = 5'($urandom);
            i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
            i_alusrc = 1'($urandom);
            i_exm_we = 1'($urandom); i_exm_addr = 5'($urandom_range(0, 3)); i_exm_data = $urandom;
            i_wb_we = 1'($urandom);  i_wb_addr = 5'($urandom_range(0, 3));  i_wb_data = $urandom;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
